gf180mcu_osu_sc_9t_clkdiv_8: RTL and testbench
==============================================

Name: gf180mcu_osu_sc_9T_clkdiv_8

Overview:
- Parametrised multi-channel clock generator. It is the next-generation successor to the single-output 9T clock buffer cell, and sits beside the clock tree in the gf180mcu_osu_sc_9T platform.
- Each channel derives a registered, 50%-duty divided clock from CLK.
- Each channel has a glitch-free start/stop enable.
- Each channel has a handshaked divide-ratio update that takes effect only on period boundaries, so downstream logic never sees runt pulses.

Parameters:
- N_CH, 4, number of independent divided-clock channels.
- DIV_W, 8, width of each channel's divide field.
- RESET_DIV, 0, divide value loaded into every channel at reset.

Ports:
- CLK  input  1  source clock. Single clock domain; the block has one clock.
- RST  input  1  reset, asynchronous, active-high.
- EN  input  N_CH  per-channel run enable, level-sensitive.
- UPD  input  N_CH  per-channel one-cycle update strobe for DIV_IN.
- DIV_IN  input  N_CH*DIV_W  per-channel new divide value. Channel i uses bits [i*DIV_W +: DIV_W].
- ACK  output  N_CH  one-cycle pulse when the pending divide value becomes active.
- BUSY  output  N_CH  channel is running (state RUN).
- Y  output  N_CH  divided clock, driven directly from a flop.

Behaviour:
- Reset (RST=1, asynchronous), all channels:
  - Y=0, ACK=0, BUSY=0.
  - State IDLE; cnt=0.
  - div_act=RESET_DIV; pend_vld=0.
- Reset mid-operation forces Y low immediately and may truncate a high phase. Consumers of Y must be held in reset for the same interval.
- Divide rule: with d=div_act, the period is 2*(d+1) CLK cycles. Y is high for d+1 cycles and low for d+1 cycles. d=0 gives CLK/2. d=255 (DIV_W=8) gives CLK/512.
- Per-channel FSM, state IDLE:
  - Y=0, BUSY=0.
  - A CLK edge that samples EN=1 sets Y=1, cnt=0 and moves to RUN. Y is high from the following cycle, so start latency is 1 cycle.
  - If pend_vld=1 at that same edge, the pending value is loaded first, so the first period already uses the new ratio.
- Per-channel FSM, state RUN:
  - BUSY=1.
  - Each edge: if cnt==div_act then cnt<=0 and Y toggles; else cnt<=cnt+1.
  - Period boundary = the edge where Y would go 0->1.
    - If EN=0 there: go to IDLE and Y stays 0. Stop is always after a complete low phase; no truncated high pulse is ever produced.
    - Otherwise, if pend_vld=1: div_act<=pend, pend_vld<=0, ACK=1 for one cycle.
  - EN falling mid-period has no effect until the next period boundary.
- Update handshake:
  - The UPD edge captures DIV_IN into pend and sets pend_vld.
  - A second UPD before the value is applied overwrites pend: last write wins, and only one ACK is produced.
  - UPD on the same edge as a period boundary is not applied at that boundary; it waits for the next one.
  - In IDLE the pending value is applied on the edge after capture, with ACK high in the cycle div_act changes. Latency: UPD at edge t gives ACK high during t+1..t+2.
- ACK and BUSY are registered. ACK never stays high for two consecutive cycles for a single update.
- Channels are fully independent; there is no phase alignment between channels.
- cnt is DIV_W bits wide. Comparison uses equality only, so no wrap-around hazard exists: cnt never exceeds div_act, because a ratio change only occurs when cnt=0.

Decomposition:
- Shared platform include/package holds:
  - state encodings (ST_IDLE=1'b0, ST_RUN=1'b1);
  - default DIV_W;
  - the period formula constant used by the bench.
- One sub-module, gf180mcu_osu_sc_9T_clkdiv_ch, is natural. It implements a single channel (FSM, counter, pend/div_act registers).
- The top level generates N_CH instances and slices DIV_IN.

Test Plan:
- Reset defaults: assert RST mid-run with d=3, Y high → Y, ACK, BUSY go 0 asynchronously. After release with EN=1, Y toggles every 1 cycle (RESET_DIV=0), giving period 2.
- Basic divide: UPD with DIV_IN=2 in IDLE → ACK pulse 1 cycle later. Then EN=1 → Y high 3 cycles / low 3 cycles, period 6; BUSY=1 from the cycle after EN is sampled.
- Ratio change at boundary: running d=1 (period 4), UPD DIV_IN=4 mid high phase → current period completes as 2H/2L. ACK coincides with the next rise; subsequent periods are 5H/5L.
- Overwrite: two UPDs (DIV_IN=5, then 7) within one period at d=3 → exactly one ACK; the new period is 8H/8L.
- Glitch-free stop: EN drops during the 2nd cycle of a 4-cycle high phase (d=3) → Y completes 4H+4L, then stays 0. BUSY drops at that boundary and there is no runt pulse.
- Channel independence: ch0 d=0, ch3 d=7, both enabled, UPD on ch3 only → ch0 period 2 is undisturbed; ACK asserts only on bit 3.

Source files
------------

// File: rtl/gf180mcu_osu_sc_9t_clkdiv_8_pkg.sv
// rtl/gf180mcu_osu_sc_9t_clkdiv_8_pkg.sv - shared types and constants for the multi-channel clock divider
package gf180mcu_osu_sc_9t_clkdiv_8_pkg;

  // Per-channel FSM encoding
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

  // Default width of each channel's divide field
  localparam int DIV_W_DEF = 8;

  // Output period in source-clock cycles for divide value d
  function automatic int period_cycles(input int d);
    return 2 * (d + 1);
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_9t_clkdiv_8_ch.sv
// rtl/gf180mcu_osu_sc_9t_clkdiv_8_ch.sv - one divided-clock channel with glitch-free enable and boundary-aligned ratio update
module gf180mcu_osu_sc_9t_clkdiv_8_ch
  import gf180mcu_osu_sc_9t_clkdiv_8_pkg::*;
#(
  parameter int DIV_W     = DIV_W_DEF,
  parameter int RESET_DIV = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             upd,
  input  logic [DIV_W-1:0] div_in,
  output logic             ack,
  output logic             busy,
  output logic             y
);

  ch_state_t        state;
  ch_state_t        state_nxt;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] pend;
  logic             pend_vld;
  logic             at_term;
  logic             boundary;
  logic             apply;

  // Last cycle of a phase; in RUN with Y low this is the period boundary (Y would rise)
  assign at_term  = (cnt == div_act);
  assign boundary = (state == ST_RUN) && at_term && !y;
  // A pending ratio is taken whenever idle, or at a boundary that keeps running
  assign apply    = pend_vld && ((state == ST_IDLE) || (boundary && en));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: start on any sampled EN, stop only at a period boundary
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en) state_nxt = ST_RUN;
      ST_RUN:  if (boundary && !en) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: BUSY comes straight from the state flop
  always_comb begin
    busy = (state == ST_RUN);
  end

  // Ratio handshake: capture on UPD (last write wins), apply with a one-cycle ACK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_act  <= DIV_W'(RESET_DIV);
      pend     <= '0;
      pend_vld <= 1'b0;
      ack      <= 1'b0;
    end else begin
      ack <= apply;
      if (apply) div_act <= pend;
      if (upd) begin
        pend     <= div_in;
        pend_vld <= 1'b1;
      end else if (apply) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // Divider: count each phase to div_act, toggle Y; a stop leaves Y low at the boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y   <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (en) y <= 1'b1;
        end
        ST_RUN: begin
          if (at_term) begin
            cnt <= '0;
            if (y)       y <= 1'b0;
            else if (en) y <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          y   <= 1'b0;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gf180mcu_osu_sc_9t_clkdiv_8.sv
// rtl/gf180mcu_osu_sc_9t_clkdiv_8.sv - N_CH independent divided-clock channels
module gf180mcu_osu_sc_9t_clkdiv_8
  import gf180mcu_osu_sc_9t_clkdiv_8_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DIV_W     = DIV_W_DEF,
  parameter int RESET_DIV = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_CH-1:0]       EN,
  input  logic [N_CH-1:0]       UPD,
  input  logic [N_CH*DIV_W-1:0] DIV_IN,
  output logic [N_CH-1:0]       ACK,
  output logic [N_CH-1:0]       BUSY,
  output logic [N_CH-1:0]       Y
);

  // One channel per bit; channel i owns DIV_IN[i*DIV_W +: DIV_W]
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    gf180mcu_osu_sc_9t_clkdiv_8_ch #(
      .DIV_W     (DIV_W),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clk    (CLK),
      .rst    (RST),
      .en     (EN[i]),
      .upd    (UPD[i]),
      .div_in (DIV_IN[i*DIV_W +: DIV_W]),
      .ack    (ACK[i]),
      .busy   (BUSY[i]),
      .y      (Y[i])
    );
  end

endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_clkdiv_8.sv
// tb/tb_gf180mcu_osu_sc_9t_clkdiv_8.sv - randomized self-checking bench with a period-position reference model
module tb_gf180mcu_osu_sc_9t_clkdiv_8;

  localparam int N_CH  = 4;
  localparam int DIV_W = 8;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [N_CH-1:0]       EN;
  logic [N_CH-1:0]       UPD;
  logic [N_CH*DIV_W-1:0] DIV_IN;
  logic [N_CH-1:0]       ACK;
  logic [N_CH-1:0]       BUSY;
  logic [N_CH-1:0]       Y;

  gf180mcu_osu_sc_9t_clkdiv_8 #(
    .N_CH      (N_CH),
    .DIV_W     (DIV_W),
    .RESET_DIV (0)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (EN),
    .UPD    (UPD),
    .DIV_IN (DIV_IN),
    .ACK    (ACK),
    .BUSY   (BUSY),
    .Y      (Y)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: each running channel is a position within its 2*(d+1) period
  bit m_run [N_CH];
  int m_pos [N_CH];
  int m_div [N_CH];
  int m_pend[N_CH];
  bit m_pv  [N_CH];
  bit m_ack [N_CH];

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_run[c] = 0; m_pos[c] = 0; m_div[c] = 0;
      m_pend[c] = 0; m_pv[c] = 0; m_ack[c] = 0;
    end
  endtask

  task automatic model_edge(input logic [N_CH-1:0] en, input logic [N_CH-1:0] upd,
                            input logic [N_CH*DIV_W-1:0] din);
    for (int c = 0; c < N_CH; c++) begin
      bit had_pend = m_pv[c];
      m_ack[c] = 0;
      if (!m_run[c]) begin
        if (had_pend) begin
          m_div[c] = m_pend[c]; m_pv[c] = 0; m_ack[c] = 1;
        end
        if (en[c]) begin
          m_run[c] = 1; m_pos[c] = 0;
        end
      end else begin
        m_pos[c]++;
        if (m_pos[c] == 2 * (m_div[c] + 1)) begin
          m_pos[c] = 0;
          if (!en[c]) m_run[c] = 0;
          else if (had_pend) begin
            m_div[c] = m_pend[c]; m_pv[c] = 0; m_ack[c] = 1;
          end
        end
      end
      if (upd[c]) begin
        m_pend[c] = int'(din[c*DIV_W +: DIV_W]);
        m_pv[c]   = 1;
      end
    end
  endtask

  function automatic logic [N_CH-1:0] exp_y();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = m_run[c] && (m_pos[c] <= m_div[c]);
    return v;
  endfunction

  function automatic logic [N_CH-1:0] exp_busy();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = m_run[c];
    return v;
  endfunction

  function automatic logic [N_CH-1:0] exp_ack();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = m_ack[c];
    return v;
  endfunction

  function automatic logic [N_CH*DIV_W-1:0] put(input logic [N_CH*DIV_W-1:0] din, input int c, input int v);
    logic [N_CH*DIV_W-1:0] r = din;
    r[c*DIV_W +: DIV_W] = DIV_W'(v);
    return r;
  endfunction

  logic [N_CH-1:0] cur_en = '0;

  // One clock: drive at negedge, step model at posedge, compare 1 time unit later
  task automatic cycle(input logic [N_CH-1:0] upd, input logic [N_CH*DIV_W-1:0] din);
    @(negedge CLK);
    EN = cur_en; UPD = upd; DIV_IN = din;
    @(posedge CLK);
    model_edge(cur_en, upd, din);
    #1;
    chk("y", 32'(Y), 32'(exp_y()));
    chk("ack", 32'(ACK), 32'(exp_ack()));
    chk("busy", 32'(BUSY), 32'(exp_busy()));
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle('0, '0);
  endtask

  task automatic async_reset_check();
    RST = 1'b1;
    #1;
    chk("rst_y", 32'(Y), 32'h0);
    chk("rst_ack", 32'(ACK), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    model_reset();
    cur_en = '0;
    @(negedge CLK);
    EN = '0; UPD = '0; DIV_IN = '0;
    RST = 1'b0;
  endtask

  initial begin
    bit found;
    RST = 1'b1; EN = '0; UPD = '0; DIV_IN = '0;
    model_reset();
    #12;
    chk("por_y", 32'(Y), 32'h0);
    chk("por_ack", 32'(ACK), 32'h0);
    chk("por_busy", 32'(BUSY), 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    // Reset divide value: CLK/2 on ch0, then stop
    cur_en = 4'b0001; idle_cycles(8);
    cur_en = 4'b0000; idle_cycles(4);

    // Update in IDLE then run at d=2
    cycle(4'b0001, put('0, 0, 2));
    idle_cycles(2);
    cur_en = 4'b0001; idle_cycles(14);

    // ch1 at d=1, change to 4 during a high phase
    cycle(4'b0010, put('0, 1, 1));
    idle_cycles(1);
    cur_en = 4'b0011; idle_cycles(4);
    cycle(4'b0010, put('0, 1, 4));
    idle_cycles(24);

    // ch2 at d=3, two updates within one period
    cycle(4'b0100, put('0, 2, 3));
    idle_cycles(1);
    cur_en = 4'b0111; idle_cycles(9);
    cycle(4'b0100, put('0, 2, 5));
    idle_cycles(1);
    cycle(4'b0100, put('0, 2, 7));
    idle_cycles(40);

    // ch3 at d=3, EN drops in the 2nd high cycle
    cycle(4'b1000, put('0, 3, 3));
    idle_cycles(1);
    cur_en = 4'b1111; idle_cycles(2);
    cur_en = 4'b0111; idle_cycles(12);

    // Independence: ch0 d=0, ch3 d=7, update ch3 only while both run
    cycle(4'b0001, put('0, 0, 0));
    idle_cycles(4);
    cycle(4'b1000, put('0, 3, 7));
    idle_cycles(2);
    cur_en = 4'b1111; idle_cycles(6);
    cycle(4'b1000, put('0, 3, 2));
    idle_cycles(40);

    // Asynchronous reset while ch0 runs at d=3 with Y high
    cycle(4'b0001, put('0, 0, 3));
    idle_cycles(12);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle('0, '0);
      if (exp_y()[0] && m_div[0] == 3) found = 1;
    end
    chk("rst_setup_found", 32'(found), 32'h1);
    async_reset_check();
    cur_en = 4'b0001; idle_cycles(10);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [N_CH-1:0]       upd = '0;
      logic [N_CH*DIV_W-1:0] din = '0;
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 15) == 0) cur_en[c] = ~cur_en[c];
        if ($urandom_range(0, 19) == 0) begin
          upd[c] = 1'b1;
          din = put(din, c, ($urandom_range(0, 59) == 0) ? 255 : int'($urandom_range(0, 9)));
        end else begin
          din = put(din, c, int'($urandom_range(0, 255)));
        end
      end
      cycle(upd, din);
      if (n == 1500) async_reset_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
